// File: rtl/pcm_i2s_rx_pkg.sv
// Shared types and constants for the I2S receive path (package pcm_pkg).
package pcm_pkg;

    typedef enum logic [1:0] {
        WAIT_LEFT,
        LEFT,
        RIGHT
    } state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;
    localparam int   PCM_DW   = 16;

endpackage

// File: rtl/pcm_i2s_rx_edge_det.sv
// Oversamples bclk/ws/sdata in the clk domain and flags each bclk rising edge.
// Define PCM_RX_SYNC_EN to insert 2-flop synchronizers for an asynchronous bclk source.
module pcm_edge_det
    import pcm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bclk_i,
    input  logic ws_i,
    input  logic sdata_i,
    output logic rise_o,
    output logic ws_s_o,
    output logic sdata_s_o
);

    logic bclkIn;
    logic bclk_q;

`ifdef PCM_RX_SYNC_EN
    logic [1:0] bclkSync_q;
    logic [1:0] wsSync_q;
    logic [1:0] sdataSync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclkSync_q  <= '0;
            wsSync_q    <= '0;
            sdataSync_q <= '0;
        end else begin
            bclkSync_q  <= {bclkSync_q[0], bclk_i};
            wsSync_q    <= {wsSync_q[0], ws_i};
            sdataSync_q <= {sdataSync_q[0], sdata_i};
        end
    end

    assign bclkIn    = bclkSync_q[1];
    assign ws_s_o    = wsSync_q[1];
    assign sdata_s_o = sdataSync_q[1];
`else
    assign bclkIn    = bclk_i;
    assign ws_s_o    = ws_i;
    assign sdata_s_o = sdata_i;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_q <= 1'b0;
        end else begin
            bclk_q <= bclkIn;
        end
    end

    assign rise_o = bclkIn & ~bclk_q;

endmodule

// File: rtl/pcm_i2s_rx.sv
// I2S receiver: deserializes left/right words and hands out stereo pairs over valid/ready.
// Optional macro PCM_RX_SYNC_EN (in pcm_edge_det) adds input synchronizers.
module pcm_i2s_rx
    import pcm_pkg::*;
#(
    parameter int DW = PCM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bclk,
    input  logic          ws,
    input  logic          sdata,
    input  logic          out_ready,
    input  logic          ovr_clr,
    output logic [DW-1:0] out_left,
    output logic [DW-1:0] out_right,
    output logic          out_valid,
    output logic          overrun
);

    localparam int CW = $clog2(DW + 1);

    logic          rise;
    logic          wsS;
    logic          sdataS;

    state_t        state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [DW-1:0] leftHold_q, leftHold_d;
    logic [DW-1:0] outLeft_q, outLeft_d;
    logic [DW-1:0] outRight_q, outRight_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wsPrev_q, wsPrev_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic [DW-1:0] placed;
    logic [CW-1:0] cntInc;
    logic          boundary;

    pcm_edge_det uEdgeDet (
        .clk       (clk),
        .reset     (reset),
        .bclk_i    (bclk),
        .ws_i      (ws),
        .sdata_i   (sdata),
        .rise_o    (rise),
        .ws_s_o    (wsS),
        .sdata_s_o (sdataS)
    );

    // The bit of a boundary event still belongs to the ending word (I2S one-bit delay),
    // so it is placed first and the word is committed from the updated register.
    always_comb begin
        placed = shreg_q;
        for (int i = 0; i < DW; i++) begin
            if (cnt_q == CW'(DW - 1 - i)) begin
                placed[i] = sdataS;
            end
        end
        cntInc   = (cnt_q < CW'(DW)) ? cnt_q + CW'(1) : cnt_q;
        boundary = rise && (wsS != wsPrev_q);

        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        leftHold_d = leftHold_q;
        outLeft_d  = outLeft_q;
        outRight_d = outRight_q;
        wsPrev_d   = rise ? wsS : wsPrev_q;
        valid_d    = valid_q && !out_ready;
        ovr_d      = ovr_q && !ovr_clr;

        if (rise) begin
            case (state_q)
                WAIT_LEFT: begin
                    if (boundary && wsS == CH_LEFT) begin
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = LEFT;
                    end
                end
                LEFT: begin
                    if (boundary) begin
                        leftHold_d = placed;
                        shreg_d    = '0;
                        cnt_d      = '0;
                        state_d    = RIGHT;
                    end else begin
                        shreg_d = placed;
                        cnt_d   = cntInc;
                    end
                end
                RIGHT: begin
                    if (boundary) begin
                        if (!valid_q || out_ready) begin
                            outLeft_d  = leftHold_q;
                            outRight_d = placed;
                            valid_d    = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = LEFT;
                    end else begin
                        shreg_d = placed;
                        cnt_d   = cntInc;
                    end
                end
                default: state_d = WAIT_LEFT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= WAIT_LEFT;
            shreg_q    <= '0;
            cnt_q      <= '0;
            leftHold_q <= '0;
            outLeft_q  <= '0;
            outRight_q <= '0;
            wsPrev_q   <= 1'b0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            leftHold_q <= leftHold_d;
            outLeft_q  <= outLeft_d;
            outRight_q <= outRight_d;
            wsPrev_q   <= wsPrev_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign out_left  = outLeft_q;
    assign out_right = outRight_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_pcm_i2s_rx.sv
// Self-checking bench for pcm_i2s_rx: drives I2S frames at bclk = clk/8 and scoreboards pairs.
module tb_pcm_i2s_rx;
    import pcm_pkg::*;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          clk;
    logic          reset;
    logic          bclk;
    logic          ws;
    logic          sdata;
    logic          out_ready;
    logic          ovr_clr;
    logic [DW-1:0] out_left;
    logic [DW-1:0] out_right;
    logic          out_valid;
    logic          overrun;

    int    vectors;
    int    miscompares;
    pair_t expQ[$];
    logic  ovrCheck;
    logic  pendLsb;

    pcm_i2s_rx #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bclk      (bclk),
        .ws        (ws),
        .sdata     (sdata),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A word of len bits is left-justified into DW bits: short words get zero LSBs, long ones lose LSBs.
    function automatic logic [DW-1:0] justify(logic [31:0] val, int len);
        logic [63:0] w;
        w = {32'b0, val} << (64 - len);
        return w[63:64-DW];
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bclk period (8 clk): ws/sdata set while bclk is low, sampled on its rise.
    task automatic applyStimulus(logic w, logic d);
        bclk  = 1'b0;
        ws    = w;
        sdata = d;
        tick(4);
        bclk = 1'b1;
        tick(4);
    endtask

    // The first slot of a ws period carries the LSB of the previous word.
    task automatic sendWord(logic w, logic [31:0] val, int len);
        applyStimulus(w, pendLsb);
        for (int i = len - 1; i >= 1; i--) begin
            applyStimulus(w, val[i]);
        end
        pendLsb = val[0];
    endtask

    task automatic sendFrame(logic [31:0] l, int nl, logic [31:0] r, int nr);
        sendWord(CH_LEFT, l, nl);
        sendWord(CH_RIGHT, r, nr);
    endtask

    task automatic expectPair(logic [31:0] l, int nl, logic [31:0] r, int nr);
        pair_t p;
        p.l = justify(l, nl);
        p.r = justify(r, nr);
        expQ.push_back(p);
    endtask

    task automatic waitDrain(string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        checkOutput(name, expQ.size(), 0);
    endtask

    // Every accepted pair must be the oldest expected one; overrun must stay low unless a drop is staged.
    always @(negedge clk) begin
        if (reset) begin
            if (ovrCheck) begin
                checkOutput("overrun_idle", overrun, 0);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pair", {out_left, out_right}, 0);
                end else begin
                    pair_t p;
                    p = expQ.pop_front();
                    checkOutput("pair_left", out_left, p.l);
                    checkOutput("pair_right", out_right, p.r);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        ovrCheck    = 1'b0;
        pendLsb     = 1'b0;
        reset       = 1'b0;
        bclk        = 1'b0;
        ws          = 1'b0;
        sdata       = 1'b0;
        out_ready   = 1'b1;
        ovr_clr     = 1'b0;

        checkOutput("model_16b", justify(32'hA5A5, 16), 32'hA5A5);
        checkOutput("model_12b", justify(32'h0ABC, 12), 32'hABC0);
        checkOutput("model_18b", justify(32'h2FFFF, 18), 32'hBFFF);

        tick(3);
        checkOutput("reset_left", out_left, 0);
        checkOutput("reset_right", out_right, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_overrun", overrun, 0);
        reset    = 1'b1;
        ovrCheck = 1'b1;
        tick(2);

        $display("[TB] partial right word, then full frames");
        sendWord(CH_RIGHT, 32'h15, 5);
        expectPair(32'hA5A5, 16, 32'h1234, 16);
        sendFrame(32'hA5A5, 16, 32'h1234, 16);
        expectPair(32'hA5A5, 16, 32'h1234, 16);
        sendFrame(32'hA5A5, 16, 32'h1234, 16);
        expectPair(32'h0ABC, 12, 32'h0123, 12);
        sendFrame(32'h0ABC, 12, 32'h0123, 12);
        expectPair(32'h2FFFF, 18, 32'h10001, 18);
        sendFrame(32'h2FFFF, 18, 32'h10001, 18);
        expectPair(32'h1111, 16, 32'h2222, 16);
        sendFrame(32'h1111, 16, 32'h2222, 16);

        $display("[TB] backpressure and overrun");
        out_ready = 1'b0;
        ovrCheck  = 1'b0;
        sendFrame(32'h3333, 16, 32'h4444, 16);
        sendWord(CH_LEFT, 32'h5555, 16);
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_left", out_left, 32'h1111);
        checkOutput("hold_right", out_right, 32'h2222);
        checkOutput("overrun_set", overrun, 1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        checkOutput("overrun_clr", overrun, 0);
        ovrCheck  = 1'b1;
        out_ready = 1'b1;
        waitDrain("drain_held");

        $display("[TB] reset mid left word");
        out_ready = 1'b0;
        sendWord(CH_RIGHT, 32'h6666, 16);
        applyStimulus(CH_LEFT, pendLsb);
        tick(2);
        checkOutput("prereset_valid", out_valid, 1);
        checkOutput("prereset_left", out_left, 32'h5555);
        applyStimulus(CH_LEFT, 1'b1);
        applyStimulus(CH_LEFT, 1'b0);
        bclk  = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("midreset_valid", out_valid, 0);
        checkOutput("midreset_left", out_left, 0);
        checkOutput("midreset_right", out_right, 0);
        tick(3);
        reset     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(CH_LEFT, 1'b1);
        applyStimulus(CH_LEFT, 1'b1);
        sendWord(CH_RIGHT, 32'h0F0F, 16);
        expectPair(32'h1357, 16, 32'h2468, 16);
        sendFrame(32'h1357, 16, 32'h2468, 16);
        sendWord(CH_LEFT, 32'h0000, 16);
        waitDrain("drain_final");
        tick(20);
        checkOutput("final_valid", out_valid, 0);
        checkOutput("final_overrun", overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
